// File: rtl/data_ram.sv
// Byte-addressable, big-endian data memory answering the control unit's
// MOV/MOC four-phase handshake after a fixed, parameterised latency.
module data_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MOV,
   input  logic                  RW,
   input  logic [1:0]            DL,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           data_in,
   output logic [31:0]           data_out,
   output logic                  MOC,
   output logic                  misaligned
);

   localparam int         DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              count;
   logic                    rw_q;
   logic [1:0]              size_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic                    mis_q;
   logic [ADDR_WIDTH-1:0]   eff_addr;
   logic                    mis_in;
   logic                    accept;
   logic                    commit;
   logic [ADDR_WIDTH-1:0]   a1, a2, a3;
   logic [31:0]             rd_data;
   logic [7:0]              mem [0:DEPTH-1];

   // DL = 11 falls into the default arm, so it behaves as a word access
   always_comb begin
      eff_addr = address;
      mis_in   = 1'b0;
      case (DL)
         2'b00: eff_addr = address;
         2'b01: begin
            eff_addr[0] = 1'b0;
            mis_in      = address[0];
         end
         default: begin
            eff_addr[1:0] = 2'b00;
            mis_in        = |address[1:0];
         end
      endcase
   end

   assign accept = (state == IDLE) && MOV;
   assign commit = (state == BUSY) && (count == 4'd0);

   assign a1 = {addr_q[ADDR_WIDTH-1:1], 1'b1};
   assign a2 = {addr_q[ADDR_WIDTH-1:2], 2'b10};
   assign a3 = {addr_q[ADDR_WIDTH-1:2], 2'b11};

   always_comb begin
      case (size_q)
         2'b00:   rd_data = {24'h0, mem[addr_q]};
         2'b01:   rd_data = {16'h0, mem[addr_q], mem[a1]};
         default: rd_data = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (MOV) state_nxt = BUSY;
         BUSY:    if (count == 4'd0) state_nxt = DONE;
         DONE:    if (!MOV) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      MOC        = (state == DONE);
      misaligned = (state == DONE) && mis_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= 4'd0;
         mis_q    <= 1'b0;
         data_out <= 32'h0;
      end else begin
         if (accept) begin
            count <= LAT_M1;
            mis_q <= mis_in;
         end else if ((state == BUSY) && (count != 4'd0)) begin
            count <= count - 4'd1;
         end
         if (commit && rw_q) data_out <= rd_data;
      end
   end

   // Request fields are captured once at acceptance and frozen until the next one
   always_ff @(posedge clk) begin
      if (accept) begin
         rw_q    <= RW;
         size_q  <= DL;
         addr_q  <= eff_addr;
         wdata_q <= data_in;
      end
   end

   // The array is never reset; reset only suppresses an in-flight write
   always_ff @(posedge clk) begin
      if (!reset && commit && !rw_q) begin
         case (size_q)
            2'b00: mem[addr_q] <= wdata_q[7:0];
            2'b01: begin
               mem[addr_q] <= wdata_q[15:8];
               mem[a1]     <= wdata_q[7:0];
            end
            default: begin
               mem[addr_q] <= wdata_q[31:24];
               mem[a1]     <= wdata_q[23:16];
               mem[a2]     <= wdata_q[15:8];
               mem[a3]     <= wdata_q[7:0];
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: three instances (LATENCY 2, 1, 4) share one request bus;
// a vector table plus hand-built reset sequences exercise the handshake.
module tb_data_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, MOV, RW;
   logic [1:0]       DL;
   logic [7:0]       address;
   logic [31:0]      data_in;
   logic [2:0][31:0] dout;
   logic [2:0]       moc, mis;

   data_ram #(.ADDR_WIDTH(8), .LATENCY(2)) dut_l2 (
      .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .DL(DL), .address(address),
      .data_in(data_in), .data_out(dout[0]), .MOC(moc[0]), .misaligned(mis[0]));
   data_ram #(.ADDR_WIDTH(8), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .DL(DL), .address(address),
      .data_in(data_in), .data_out(dout[1]), .MOC(moc[1]), .misaligned(mis[1]));
   data_ram #(.ADDR_WIDTH(8), .LATENCY(4)) dut_l4 (
      .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .DL(DL), .address(address),
      .data_in(data_in), .data_out(dout[2]), .MOC(moc[2]), .misaligned(mis[2]));

   typedef struct {
      logic        rw;
      logic [1:0]  dl;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_mis;
   } vec_t;

   int   lat_exp [3] = '{2, 1, 4};
   vec_t exp_q [$];
   vec_t vecs [16];
   int   applied = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input int tag, input int d,
                      input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s txn %0d dut %0d: got %h, expected %h", name, tag, d, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rw, input logic [1:0] dl, input logic [7:0] a,
                               input logic [31:0] wd, input logic [31:0] ed, input logic em);
      vec_t v;
      v.rw = rw; v.dl = dl; v.addr = a; v.wdata = wd; v.exp_data = ed; v.exp_mis = em;
      return v;
   endfunction

   // One full four-phase transaction; request inputs are scrambled once accepted
   task automatic do_txn(input int tag, input vec_t v, input int hold, input bit rst_done);
      int   got [3];
      vec_t e;
      got = '{0, 0, 0};
      @(negedge clk);
      MOV = 1'b1; RW = v.rw; DL = v.dl; address = v.addr; data_in = v.wdata;
      exp_q.push_back(v);
      @(posedge clk); #1;
      address = 8'($urandom); data_in = $urandom; RW = ~v.rw; DL = 2'($urandom);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) if (got[d] == 0 && moc[d]) got[d] = k;
         if (got[0] != 0 && got[1] != 0 && got[2] != 0) break;
      end
      e = exp_q.pop_front();
      for (int d = 0; d < 3; d++) begin
         chk("latency", tag, d, got[d], lat_exp[d]);
         chk("data_out", tag, d, dout[d], e.exp_data);
         chk("misaligned", tag, d, {31'h0, mis[d]}, {31'h0, e.exp_mis});
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) chk("moc_hold", tag, d, {31'h0, moc[d]}, 32'h1);
      end
      @(negedge clk);
      MOV = 1'b0;
      if (rst_done) reset = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         chk("moc_fall", tag, d, {31'h0, moc[d]}, 32'h0);
         chk("mis_fall", tag, d, {31'h0, mis[d]}, 32'h0);
         chk("data_hold", tag, d, dout[d], rst_done ? 32'h0 : e.exp_data);
      end
      if (rst_done) begin
         @(negedge clk);
         reset = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; MOV = 1'b0; RW = 1'b1; DL = 2'b00; address = 8'h0; data_in = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_moc", 0, d, {31'h0, moc[d]}, 32'h0);
         chk("rst_dout", 0, d, dout[d], 32'h0);
         chk("rst_mis", 0, d, {31'h0, mis[d]}, 32'h0);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) chk("idle_moc", 0, d, {31'h0, moc[d]}, 32'h0);
      end

      vecs[0]  = mk(1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
      vecs[1]  = mk(1'b1, 2'b00, 8'h10, 32'h0,        32'h000000DE, 1'b0);
      vecs[2]  = mk(1'b1, 2'b00, 8'h11, 32'h0,        32'h000000AD, 1'b0);
      vecs[3]  = mk(1'b1, 2'b00, 8'h12, 32'h0,        32'h000000BE, 1'b0);
      vecs[4]  = mk(1'b1, 2'b00, 8'h13, 32'h0,        32'h000000EF, 1'b0);
      vecs[5]  = mk(1'b1, 2'b10, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0);
      vecs[6]  = mk(1'b0, 2'b00, 8'h11, 32'hFFFFFF55, 32'hDEADBEEF, 1'b0);
      vecs[7]  = mk(1'b1, 2'b10, 8'h10, 32'h0,        32'hDE55BEEF, 1'b0);
      vecs[8]  = mk(1'b1, 2'b01, 8'h12, 32'h0,        32'h0000BEEF, 1'b0);
      vecs[9]  = mk(1'b1, 2'b01, 8'h13, 32'h0,        32'h0000BEEF, 1'b1);
      vecs[10] = mk(1'b0, 2'b10, 8'h22, 32'hA1B2C3D4, 32'h0000BEEF, 1'b1);
      vecs[11] = mk(1'b1, 2'b11, 8'h20, 32'h0,        32'hA1B2C3D4, 1'b0);
      vecs[12] = mk(1'b1, 2'b10, 8'h21, 32'h0,        32'hA1B2C3D4, 1'b1);
      vecs[13] = mk(1'b0, 2'b01, 8'h31, 32'hFFFF1234, 32'hA1B2C3D4, 1'b1);
      vecs[14] = mk(1'b1, 2'b01, 8'h30, 32'h0,        32'h00001234, 1'b0);
      vecs[15] = mk(1'b1, 2'b00, 8'h31, 32'h0,        32'h00000034, 1'b0);

      for (int i = 0; i < 16; i++) do_txn(i + 1, vecs[i], (i == 5) ? 6 : 0, 1'b0);

      // Reset lands in BUSY of a word write, then stays up one more edge with MOV high
      @(negedge clk);
      MOV = 1'b1; RW = 1'b0; DL = 2'b10; address = 8'h20; data_in = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) chk("busy_rst_moc", 90, d, {31'h0, moc[d]}, 32'h0);
      end
      @(negedge clk);
      reset = 1'b0; MOV = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            chk("post_rst_moc", 91, d, {31'h0, moc[d]}, 32'h0);
            chk("post_rst_dout", 91, d, dout[d], 32'h0);
         end
      end
      do_txn(100, mk(1'b1, 2'b10, 8'h20, 32'h0, 32'hA1B2C3D4, 1'b0), 0, 1'b0);

      // Reset in DONE keeps the committed write
      do_txn(101, mk(1'b0, 2'b10, 8'h51, 32'h0BADF00D, 32'hA1B2C3D4, 1'b1), 2, 1'b1);
      do_txn(102, mk(1'b1, 2'b10, 8'h50, 32'h0, 32'h0BADF00D, 1'b0), 0, 1'b0);
      do_txn(103, mk(1'b1, 2'b00, 8'h53, 32'h0, 32'h0000000D, 1'b0), 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/data_ram.md
# data_ram

Byte-addressable synchronous data memory that responds to the control unit's memory-request interface. The control unit drives MOV, RW, DL and the address and data from MAR/MDR; this block answers with MOC and read data after a programmable latency. It replaces the constant `MOC = 1` tie-off used in control-unit benches and is the memory end of the datapath.

## Interface
- `ADDR_WIDTH`, 8: byte address width; depth = 2^ADDR_WIDTH bytes.
- `LATENCY`, 2: cycles from request acceptance to MOC assertion; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears the FSM and outputs, not the memory array.
- `MOV` in 1: memory-operation-valid request from the control unit.
- `RW` in 1: 1 = read, 0 = write.
- `DL` in 2: data size. 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- `address` in ADDR_WIDTH: byte address, from MAR.
- `data_in` in 32: write data, from MDR, right-justified.
- `data_out` out 32: read data, right-justified and zero-extended.
- `MOC` out 1: memory-operation-complete.
- `misaligned` out 1: set with MOC when the request address was not size-aligned.

## Operation
- Storage is a byte array `mem[0 .. 2^ADDR_WIDTH-1]`. Multi-byte accesses are big-endian: the byte at the lowest address is the most significant.
- Effective address:
  - Byte: `address`.
  - Halfword: `address` with bit 0 forced to 0.
  - Word: `address` with bits [1:0] forced to 0.
  - When any forced bit was 1, `misaligned` = 1 for that transaction.
- FSM states:
  - IDLE: MOC = 0. If MOV = 1, latch RW, DL, effective address, `data_in` and the misaligned flag, and load the counter with LATENCY-1. Go to BUSY.
  - BUSY: if the counter is 0, commit the access and go to DONE; otherwise decrement. MOV, RW, DL, `address` and `data_in` are ignored in this state.
  - DONE: MOC = 1. Stay while MOV = 1. When MOV = 0, go to IDLE.
- Commit on the edge entering DONE:
  - Write: only the bytes of the latched size are updated.
  - Read: `data_out` is loaded with the bytes of the latched size, zero-extended. Sign extension is the datapath's job.
  - A write leaves `data_out` unchanged.
- Handshake is four-phase. A new request is accepted only in IDLE, so MOV must drop after MOC before the next request. A MOV that stays high through DONE→IDLE does not start a new request on that same edge. It is accepted on the next edge if still high.
- `data_out` holds its value until the next read commits.
- Reserved DL = 11 behaves exactly like DL = 10.

## Timing
- Reset values: state IDLE, counter 0, MOC 0, `misaligned` 0, `data_out` 32'h0. Memory contents are undefined after power-up and retained across reset.
- Acceptance at edge t: MOC is high from edge t+LATENCY. Read data is valid in the same cycle MOC rises.
- MOC falls on the first edge at which DONE samples MOV = 0. The earliest next acceptance is the edge after that.
- Minimum transaction period: LATENCY + 2 cycles.
- Reset in BUSY aborts the transaction. No write is performed and `data_out` is not updated.
- Reset in DONE clears MOC and `misaligned` but keeps the already-committed write.
- Reset has priority over MOV on the same edge.
- `misaligned` is valid only while MOC = 1 and clears with MOC.
- Address wrap is not permitted: effective addresses are always aligned, so a word never crosses the top of the array.

## Test plan
- Reset with MOV = 0 for 2 cycles → MOC = 0, `data_out` = 0, `misaligned` = 0. Hold MOV = 0 → MOC stays 0.
- Word write then read:
  - Write 32'hDEADBEEF at 0x10 with DL = 10 → MOC high exactly 2 edges after acceptance.
  - Read 0x10 bytes individually with DL = 00 → DE, AD, BE, EF.
  - Read 0x10 with DL = 10 → `data_out` = 32'hDEADBEEF.
- Byte write: DL = 00, 0x11 ← 8'h55.
  - Word read at 0x10 → 32'hDE55BEEF.
  - Halfword read at 0x12 → 32'h0000BEEF.
- Misalignment: halfword read at 0x13 → reads 0x12, `data_out` = 32'h0000BEEF, `misaligned` = 1 while MOC = 1.
- Handshake:
  - Hold MOV = 1 for 6 cycles → MOC stays 1 and only one transaction commits. Drop MOV → MOC falls on the next edge.
  - Change `address` and `data_in` during BUSY → no effect on the committed access.
- Reset mid-write: assert reset in BUSY of a word write of 32'h12345678 to 0x20, then read 0x20 → old contents.
- Latency sweep: LATENCY = 1 → MOC 1 edge after acceptance; LATENCY = 4 → MOC 4 edges after acceptance.
